// File: rtl/axi_sram_arbiter.sv
// Bridges the CPU inst/data SRAM-style request ports onto one AXI master port.
// Separate read and write FSMs; data reads win the read channel and wait behind pending writes.
module axi_sram_arbiter #(
  parameter logic [3:0] ID_INST = 4'd0,
  parameter logic [3:0] ID_DATA = 4'd1
) (
  input  logic        aclk,
  input  logic        aresetn,
  input  logic        inst_req,
  input  logic [31:0] inst_addr,
  input  logic [1:0]  inst_size,
  output logic        inst_addr_ok,
  output logic        inst_data_ok,
  output logic [31:0] inst_rdata,
  input  logic        data_req,
  input  logic        data_wr,
  input  logic [1:0]  data_size,
  input  logic [3:0]  data_wstrb,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_wdata,
  output logic        data_addr_ok,
  output logic        data_data_ok,
  output logic [31:0] data_rdata,
  output logic [3:0]  arid,
  output logic [31:0] araddr,
  output logic [2:0]  arsize,
  output logic        arvalid,
  input  logic        arready,
  input  logic [3:0]  rid,
  input  logic [31:0] rdata,
  input  logic        rvalid,
  output logic        rready,
  output logic [31:0] awaddr,
  output logic [2:0]  awsize,
  output logic        awvalid,
  input  logic        awready,
  output logic [31:0] wdata,
  output logic [3:0]  wstrb,
  output logic        wvalid,
  input  logic        wready,
  input  logic        bvalid,
  output logic        bready
);

  typedef enum logic [1:0] {R_IDLE = 2'd0, R_AR = 2'd1, R_R = 2'd2} rd_state_t;
  typedef enum logic [1:0] {W_IDLE = 2'd0, W_REQ = 2'd1, W_B = 2'd2} wr_state_t;

  rd_state_t   rd_state_q, rd_state_d;
  logic [31:0] rd_addr_q, rd_addr_d;
  logic [1:0]  rd_size_q, rd_size_d;
  logic [3:0]  rd_id_q, rd_id_d;

  wr_state_t   wr_state_q, wr_state_d;
  logic [31:0] wr_addr_q, wr_addr_d;
  logic [1:0]  wr_size_q, wr_size_d;
  logic [3:0]  wr_strb_q, wr_strb_d;
  logic [31:0] wr_data_q, wr_data_d;
  logic        aw_done_q, aw_done_d;
  logic        w_done_q, w_done_d;

  logic        rd_data_acc, rd_data_done, wr_acc, wr_resp_done;
  logic [31:0] rd_data_rdata;
  logic        aw_fin, w_fin;

  // Requests are only honoured out of reset so the ok outputs stay low while aresetn is asserted.
  always_comb begin
    rd_state_d    = rd_state_q;
    rd_addr_d     = rd_addr_q;
    rd_size_d     = rd_size_q;
    rd_id_d       = rd_id_q;
    rd_data_acc   = 1'b0;
    rd_data_done  = 1'b0;
    rd_data_rdata = 32'h0;
    inst_addr_ok  = 1'b0;
    inst_data_ok  = 1'b0;
    inst_rdata    = 32'h0;
    arvalid       = 1'b0;
    arid          = 4'h0;
    araddr        = 32'h0;
    arsize        = 3'h0;
    rready        = 1'b0;
    case (rd_state_q)
      R_IDLE: begin
        if (aresetn && data_req && !data_wr && wr_state_q == W_IDLE) begin
          rd_data_acc = 1'b1;
          rd_addr_d   = data_addr;
          rd_size_d   = data_size;
          rd_id_d     = ID_DATA;
          rd_state_d  = R_AR;
        end else if (aresetn && inst_req) begin
          inst_addr_ok = 1'b1;
          rd_addr_d    = inst_addr;
          rd_size_d    = inst_size;
          rd_id_d      = ID_INST;
          rd_state_d   = R_AR;
        end
      end
      R_AR: begin
        arvalid = 1'b1;
        arid    = rd_id_q;
        araddr  = rd_addr_q;
        arsize  = {1'b0, rd_size_q};
        if (arready) rd_state_d = R_R;
      end
      R_R: begin
        rready = 1'b1;
        // Beats carrying another id are drained but otherwise ignored.
        if (rvalid && rid == rd_id_q) begin
          rd_state_d = R_IDLE;
          if (rd_id_q == ID_DATA) begin
            rd_data_done  = 1'b1;
            rd_data_rdata = rdata;
          end else begin
            inst_data_ok = 1'b1;
            inst_rdata   = rdata;
          end
        end
      end
      default: rd_state_d = R_IDLE;
    endcase
  end

  always_comb begin
    wr_state_d   = wr_state_q;
    wr_addr_d    = wr_addr_q;
    wr_size_d    = wr_size_q;
    wr_strb_d    = wr_strb_q;
    wr_data_d    = wr_data_q;
    aw_done_d    = aw_done_q;
    w_done_d     = w_done_q;
    wr_acc       = 1'b0;
    wr_resp_done = 1'b0;
    awvalid      = 1'b0;
    awaddr       = 32'h0;
    awsize       = 3'h0;
    wvalid       = 1'b0;
    wdata        = 32'h0;
    wstrb        = 4'h0;
    bready       = 1'b0;
    aw_fin       = 1'b0;
    w_fin        = 1'b0;
    case (wr_state_q)
      W_IDLE: begin
        if (aresetn && data_req && data_wr) begin
          wr_acc     = 1'b1;
          wr_addr_d  = data_addr;
          wr_size_d  = data_size;
          wr_strb_d  = data_wstrb;
          wr_data_d  = data_wdata;
          aw_done_d  = 1'b0;
          w_done_d   = 1'b0;
          wr_state_d = W_REQ;
        end
      end
      W_REQ: begin
        awvalid = !aw_done_q;
        wvalid  = !w_done_q;
        awaddr  = wr_addr_q;
        awsize  = {1'b0, wr_size_q};
        wdata   = wr_data_q;
        wstrb   = wr_strb_q;
        aw_fin  = aw_done_q || awready;
        w_fin   = w_done_q || wready;
        if (aw_fin && w_fin) begin
          aw_done_d  = 1'b0;
          w_done_d   = 1'b0;
          wr_state_d = W_B;
        end else begin
          aw_done_d = aw_fin;
          w_done_d  = w_fin;
        end
      end
      W_B: begin
        bready = 1'b1;
        if (bvalid) begin
          wr_resp_done = 1'b1;
          wr_state_d   = W_IDLE;
        end
      end
      default: wr_state_d = W_IDLE;
    endcase
  end

  assign data_addr_ok = rd_data_acc || wr_acc;
  assign data_data_ok = rd_data_done || wr_resp_done;
  assign data_rdata   = rd_data_rdata;

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      rd_state_q <= R_IDLE;
      rd_addr_q  <= 32'h0;
      rd_size_q  <= 2'h0;
      rd_id_q    <= 4'h0;
      wr_state_q <= W_IDLE;
      wr_addr_q  <= 32'h0;
      wr_size_q  <= 2'h0;
      wr_strb_q  <= 4'h0;
      wr_data_q  <= 32'h0;
      aw_done_q  <= 1'b0;
      w_done_q   <= 1'b0;
    end else begin
      rd_state_q <= rd_state_d;
      rd_addr_q  <= rd_addr_d;
      rd_size_q  <= rd_size_d;
      rd_id_q    <= rd_id_d;
      wr_state_q <= wr_state_d;
      wr_addr_q  <= wr_addr_d;
      wr_size_q  <= wr_size_d;
      wr_strb_q  <= wr_strb_d;
      wr_data_q  <= wr_data_d;
      aw_done_q  <= aw_done_d;
      w_done_q   <= w_done_d;
    end
  end

endmodule
